// File: rtl/ring_osc_freq_counter.sv
`timescale 1ns/1ps
// ring_osc_freq_counter: counts synchronised rising edges of a ring-oscillator
// tap over a programmable window of clk cycles and hands the result out
// through a valid/ready handshake. Optional continuous re-arming.
module ring_osc_freq_counter #(
  parameter int unsigned GATE_W      = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              continuous,
  input  logic              count_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    HOLD
  } state_t;

  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   osc_edge;

  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              load_window;

  // Synchroniser and edge-detect history; runs in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

  // State, window counters and latched result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_int_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_int_q  <= ovf_int_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and datapath update; window (re)load is shared by IDLE start
  // and the continuous-mode restart after a handshake.
  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_int_d   = ovf_int_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    load_window = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) load_window = 1'b1;
      end
      GATE: begin
        gate_cnt_d = gate_cnt_q - GATE_ONE;
        if (osc_edge) begin
          if (edge_cnt_q == CNT_MAX) ovf_int_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + CNT_ONE;
        end
        // Last window cycle: its own edge is included in the latched result.
        if (gate_cnt_q == GATE_ONE) begin
          state_d    = HOLD;
          count_d    = edge_cnt_d;
          overflow_d = ovf_int_d;
        end
      end
      HOLD: begin
        if (count_ready) begin
          if (continuous) load_window = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_window) begin
      gate_cnt_d = gate_len;
      edge_cnt_d = '0;
      ovf_int_d  = 1'b0;
      if (gate_len == '0) begin
        state_d    = HOLD;
        count_d    = '0;
        overflow_d = 1'b0;
      end else begin
        state_d = GATE;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign count_valid = (state_q == HOLD);
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule
